// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: selects a pre-decoded digit bank and scans its digits.
// Bank switches happen only at frame boundaries. Each slot starts with anti-ghost dead time, and digits can blink.
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_SRC      = 3,
  parameter int SEG_W        = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYC     = 16,
  parameter int BLINK_FRAMES = 64,
  parameter int SEG_ACT_LOW  = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC*NUM_DIGITS*SEG_W-1:0] src_bus,
  input  logic [$clog2(NUM_SRC+1)-1:0]        sel,
  input  logic [NUM_DIGITS-1:0]               digit_en,
  input  logic [NUM_DIGITS-1:0]               blink_en,
  output logic [NUM_DIGITS-1:0]               an_n,
  output logic [SEG_W-1:0]                    seg,
  output logic [$clog2(NUM_DIGITS)-1:0]       digit_idx,
  output logic                                frame_done
);

  localparam int SEL_W = $clog2(NUM_SRC+1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SEG_W-1:0] SEG_BLANK = (SEG_ACT_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic [PS_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [SEL_W-1:0]      active_sel_q, active_sel_d;
  logic [BC_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [SEG_W-1:0]      pat;
  logic                  tick, wrap;

  always_comb begin
    tick          = (presc_q == PS_W'(SCAN_DIV-1));
    wrap          = tick && (digit_idx_q == IDX_W'(NUM_DIGITS-1));
    presc_d       = tick ? '0 : presc_q + PS_W'(1);
    digit_idx_d   = digit_idx_q;
    if (tick) digit_idx_d = wrap ? '0 : digit_idx_q + IDX_W'(1);
    frame_done_d  = wrap;
    active_sel_d  = wrap ? sel : active_sel_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES-1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end
  end

  // Out-of-range selections match no bank, so they fall through to a blank pattern.
  always_comb begin
    pat = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (active_sel_q == SEL_W'(s) && digit_idx_q == IDX_W'(d))
          pat = src_bus[(s*NUM_DIGITS+d)*SEG_W +: SEG_W];
      end
    end
    if (!digit_en[digit_idx_q] || (blink_en[digit_idx_q] && !blink_phase_q))
      pat = '0;
    seg_d  = (SEG_ACT_LOW != 0) ? ~pat : pat;
    an_n_d = '1;
    if (presc_q >= PS_W'(DEAD_CYC)) an_n_d[digit_idx_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      digit_idx_q   <= '0;
      active_sel_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      frame_done_q  <= 1'b0;
      an_n_q        <= '1;
      seg_q         <= SEG_BLANK;
    end else begin
      presc_q       <= presc_d;
      digit_idx_q   <= digit_idx_d;
      active_sel_q  <= active_sel_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_done_q  <= frame_done_d;
      an_n_q        <= an_n_d;
      seg_q         <= seg_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg        = seg_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with a fast scan (SCAN_DIV=4, DEAD_CYC=1, BLINK_FRAMES=2).
// k counts rising edges since the last reset release; outputs are sampled on the falling edge.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] src_bus;
  logic [1:0]  sel;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic [3:0]  an_n;
  logic [7:0]  seg;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  typedef struct {
    int         kk;
    logic [3:0] an;
    logic [7:0] sg;
    logic       fd;
    logic [1:0] idx;
  } vec_t;
  vec_t vecs[16];

  seg7_scan_mux #(
    .NUM_DIGITS(4), .NUM_SRC(3), .SEG_W(8), .SCAN_DIV(4),
    .DEAD_CYC(1), .BLINK_FRAMES(2), .SEG_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_bus(src_bus), .sel(sel),
    .digit_en(digit_en), .blink_en(blink_en), .an_n(an_n), .seg(seg),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d: got %h want %h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (k < target && guard < 1000) begin
      step();
      guard++;
    end
  endtask

  initial begin
    // bank0 = 3F 06 5B 4F, bank1 = 66 6D 7D 07, bank2 = 77 7C 39 5E (digit 0 lowest)
    src_bus = {8'h5E, 8'h39, 8'h7C, 8'h77,
               8'h07, 8'h7D, 8'h6D, 8'h66,
               8'h4F, 8'h5B, 8'h06, 8'h3F};
    vecs = '{
      '{1,  4'hF, 8'hC0, 1'b0, 2'd0}, '{2,  4'hE, 8'hC0, 1'b0, 2'd0},
      '{3,  4'hE, 8'hC0, 1'b0, 2'd0}, '{4,  4'hE, 8'hC0, 1'b0, 2'd1},
      '{5,  4'hF, 8'hF9, 1'b0, 2'd1}, '{6,  4'hD, 8'hF9, 1'b0, 2'd1},
      '{7,  4'hD, 8'hF9, 1'b0, 2'd1}, '{8,  4'hD, 8'hF9, 1'b0, 2'd2},
      '{9,  4'hF, 8'hA4, 1'b0, 2'd2}, '{10, 4'hB, 8'hA4, 1'b0, 2'd2},
      '{11, 4'hB, 8'hA4, 1'b0, 2'd2}, '{12, 4'hB, 8'hA4, 1'b0, 2'd3},
      '{13, 4'hF, 8'hB0, 1'b0, 2'd3}, '{14, 4'h7, 8'hB0, 1'b0, 2'd3},
      '{15, 4'h7, 8'hB0, 1'b0, 2'd3}, '{16, 4'h7, 8'hB0, 1'b1, 2'd0}
    };

    // Reset held while inputs toggle
    rst_n = 1'b0; sel = 2'd1; digit_en = 4'h0; blink_en = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel = 2'(i); digit_en = 4'(i * 5); blink_en = ~blink_en;
      chk("rst_an", 32'(an_n), 32'hF);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_fd", 32'(frame_done), 32'h0);
    end

    sel = 2'd0; digit_en = 4'hF; blink_en = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // First frame, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      run_to(vecs[i].kk);
      chk("frame_an", 32'(an_n), 32'(vecs[i].an));
      chk("frame_seg", 32'(seg), 32'(vecs[i].sg));
      chk("frame_fd", 32'(frame_done), 32'(vecs[i].fd));
      chk("frame_idx", 32'(digit_idx), 32'(vecs[i].idx));
    end

    // Source switch mid-frame takes effect only at the next frame
    run_to(21); sel = 2'd2;
    run_to(26); chk("sel_hold_d2", 32'(seg), 32'hA4);
    run_to(30); chk("sel_hold_d3", 32'(seg), 32'hB0);
    run_to(32); chk("fd_frame2", 32'(frame_done), 32'h1);
    run_to(34); chk("sel_new_d0", 32'(seg), 32'h88);
    run_to(38); chk("sel_new_d1", 32'(seg), 32'h83);

    // Out-of-range select blanks from the following frame while anodes keep scanning
    run_to(40); sel = 2'd3;
    run_to(46); chk("oor_before", 32'(seg), 32'hA1);
    run_to(50); chk("oor_seg_d1", 32'(seg), 32'hFF);
    sel = 2'd0; digit_en = 4'b1011;
    run_to(54); chk("oor_seg_d1b", 32'(seg), 32'hFF);
                chk("oor_an", 32'(an_n), 32'hD);

    // Digit 2 disabled
    run_to(66); chk("en_d0", 32'(seg), 32'hC0);
    run_to(70); chk("en_d1", 32'(seg), 32'hF9);
    run_to(74); chk("en_d2_blank", 32'(seg), 32'hFF);
                chk("en_d2_an", 32'(an_n), 32'hB);
    run_to(78); chk("en_d3", 32'(seg), 32'hB0);

    // Blink on digit 0: frames 4,5 visible, 6,7 blank, 8 visible
    run_to(80); digit_en = 4'hF; blink_en = 4'b0001;
    run_to(82);  chk("blink_f5_vis", 32'(seg), 32'hC0);
    run_to(98);  chk("blink_f6_off", 32'(seg), 32'hFF);
    run_to(102); chk("blink_f6_d1", 32'(seg), 32'hF9);
    run_to(114); chk("blink_f7_off", 32'(seg), 32'hFF);
    run_to(130); chk("blink_f8_vis", 32'(seg), 32'hC0);

    // Asynchronous reset in the middle of digit 2's slot
    run_to(138); chk("pre_rst_an", 32'(an_n), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an_n), 32'hF);
    chk("arst_seg", 32'(seg), 32'hFF);
    chk("arst_idx", 32'(digit_idx), 32'h0);
    chk("arst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    blink_en = 4'h0;
    rst_n = 1'b1;
    k = 0;
    run_to(1); chk("rel_an1", 32'(an_n), 32'hF);
    run_to(2); chk("rel_an2", 32'(an_n), 32'hE);
               chk("rel_seg2", 32'(seg), 32'hC0);
               chk("rel_idx2", 32'(digit_idx), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
